// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: crossbar geometry, configuration word width and FSM state encodings.
// The program store reader must derive CFG_W from the same geometry constants.
package prog_loader_pkg;

    localparam int NOP    = 2;
    localparam int NREG   = 1;
    localparam int NCONST = 8;
    localparam int NMEM   = 1;
    localparam int NMUX   = 1;

    localparam int CFG_W_DEFAULT = (2*NOP + NREG + 8*NMEM + 3*NMUX) *
                                   (NOP + NREG + NCONST + 4*NMEM + NMUX);

    function automatic int cfg_nbytes(input int cfg_w);
        return (cfg_w + 7) / 8;
    endfunction

    typedef enum logic [3:0] {
        LD_IDLE,
        LD_CNT_LO,
        LD_CNT_HI,
        LD_PCB,
        LD_PAYLOAD,
        LD_WRITE,
        LD_CHECK,
        LD_DONE,
        LD_ERR
    } ld_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream into the loader: an 8-bit valid/ready handshake.
interface prog_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/prog_loader_cfg_word_asm.sv
// Byte-to-word assembler: byte k lands in word bits [8k..8k+7] (MSB first, ascending word
// indexing); bits past CFG_W in the final byte are dropped. o_last flags the final byte slot.
module prog_loader_cfg_word_asm
    import prog_loader_pkg::*;
#(
    parameter int CFG_W = CFG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [7:0]       i_byte,
    output logic [0:CFG_W-1] o_word,
    output logic             o_last
);

    localparam int NBYTES = cfg_nbytes(CFG_W);
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [BCW-1:0]   r_bcnt;
    logic [0:CFG_W-1] r_word;
    logic [0:CFG_W-1] w_word_next;

    assign o_last = (r_bcnt == BCW'(NBYTES - 1));
    assign o_word = r_word;

    // Each word bit belongs to exactly one byte slot; padding positions simply have no bit here.
    for (genvar gi = 0; gi < CFG_W; gi++) begin : g_bit
        assign w_word_next[gi] = (i_load && (r_bcnt == BCW'(gi / 8))) ? i_byte[7 - (gi % 8)]
                                                                      : r_word[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
            r_word <= '0;
        end else begin
            r_word <= w_word_next;
            if (i_clear) begin
                r_bcnt <= '0;
            end else if (i_load) begin
                r_bcnt <= o_last ? '0 : r_bcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program store writer: parses a counted, checksummed byte frame, writes configuration words
// through one write port and holds the CPU in reset until a load succeeds.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CFG_W     = CFG_W_DEFAULT,
    parameter int PROG_SIZE = 64,
    parameter int AW        = 6,
    parameter int W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    prog_loader_if.slave        s_bus,
    output logic                o_prog_we,
    output logic [AW-1:0]       o_prog_addr,
    output logic [0:CFG_W-1]    o_prog_wdata,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic                o_cpu_hold,
    output logic [W-1:0]        o_start_pc
);

    ld_state_t    r_state, w_state_next;
    logic [15:0]  r_cnt;
    logic [7:0]   r_pc;
    logic [7:0]   r_chk;
    logic [AW:0]  r_idx;
    logic [W-1:0] r_start_pc;
    logic         r_release;

    logic         w_ready;
    logic         w_xfer;
    logic         w_start_go;
    logic         w_last;
    logic [AW:0]  w_idx_inc;

    assign w_xfer     = s_bus.s_valid & w_ready;
    assign w_start_go = i_start & ((r_state == LD_IDLE) | (r_state == LD_DONE) | (r_state == LD_ERR));
    assign w_idx_inc  = r_idx + 1'b1;

    prog_loader_cfg_word_asm #(.CFG_W(CFG_W)) u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start_go),
        .i_load  (w_xfer && (r_state == LD_PAYLOAD)),
        .i_byte  (s_bus.s_data),
        .o_word  (o_prog_wdata),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            LD_IDLE: begin
                if (i_start) w_state_next = LD_CNT_LO;
            end
            LD_CNT_LO: begin
                w_ready = 1'b1;
                if (w_xfer) w_state_next = LD_CNT_HI;
            end
            LD_CNT_HI: begin
                w_ready = 1'b1;
                if (w_xfer) w_state_next = LD_PCB;
            end
            LD_PCB: begin
                w_ready = 1'b1;
                if (w_xfer) begin
                    if (r_cnt > 16'(PROG_SIZE))  w_state_next = LD_ERR;
                    else if (r_cnt == 16'd0)     w_state_next = LD_CHECK;
                    else                         w_state_next = LD_PAYLOAD;
                end
            end
            LD_PAYLOAD: begin
                w_ready = 1'b1;
                if (w_xfer && w_last) w_state_next = LD_WRITE;
            end
            LD_WRITE: begin
                w_state_next = (16'(w_idx_inc) == r_cnt) ? LD_CHECK : LD_PAYLOAD;
            end
            LD_CHECK: begin
                w_ready = 1'b1;
                if (w_xfer) w_state_next = ((r_chk ^ s_bus.s_data) == 8'd0) ? LD_DONE : LD_ERR;
            end
            LD_DONE, LD_ERR: begin
                if (i_start) w_state_next = LD_CNT_LO;
            end
            default: w_state_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_pc       <= '0;
            r_chk      <= '0;
            r_idx      <= '0;
            r_start_pc <= '0;
            r_release  <= 1'b0;
        end else begin
            r_release <= (r_state == LD_DONE);
            if (w_start_go) begin
                r_cnt <= '0;
                r_chk <= '0;
                r_idx <= '0;
            end else begin
                if (w_xfer) r_chk <= r_chk ^ s_bus.s_data;
                if (w_xfer && (r_state == LD_CNT_LO)) r_cnt[7:0]  <= s_bus.s_data;
                if (w_xfer && (r_state == LD_CNT_HI)) r_cnt[15:8] <= s_bus.s_data;
                if (w_xfer && (r_state == LD_PCB))    r_pc        <= s_bus.s_data;
                if (r_state == LD_WRITE)              r_idx       <= w_idx_inc;
                if (w_xfer && (r_state == LD_CHECK) && ((r_chk ^ s_bus.s_data) == 8'd0))
                    r_start_pc <= W'(r_pc);
            end
        end
    end

    assign s_bus.s_ready = w_ready;
    assign o_prog_we     = (r_state == LD_WRITE);
    assign o_prog_addr   = r_idx[AW-1:0];
    assign o_busy        = (r_state != LD_IDLE) && (r_state != LD_DONE) && (r_state != LD_ERR);
    assign o_done        = (r_state == LD_DONE);
    assign o_err         = (r_state == LD_ERR);
    assign o_start_pc    = r_start_pc;
    // The CPU is released one cycle after DONE so start_pc is stable first; a new start re-holds it at once.
    assign o_cpu_hold    = ~((r_state == LD_DONE) & r_release & ~i_start);

endmodule

// File: tb/tb_prog_loader.sv
// Directed frames into prog_loader (CFG_W=12, PROG_SIZE=4); writes checked by a scoreboard monitor.
module tb_prog_loader;

    localparam int CFG_W     = 12;
    localparam int PROG_SIZE = 4;
    localparam int AW        = 2;
    localparam int W         = 8;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [0:CFG_W-1] data;
    } wr_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             w_prog_we;
    logic [AW-1:0]    w_prog_addr;
    logic [0:CFG_W-1] w_prog_wdata;
    logic             w_busy, w_done, w_err, w_cpu_hold;
    logic [W-1:0]     w_start_pc;

    wr_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    prog_loader_if u_if();

    prog_loader #(.CFG_W(CFG_W), .PROG_SIZE(PROG_SIZE), .AW(AW), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .s_bus        (u_if),
        .o_prog_we    (w_prog_we),
        .o_prog_addr  (w_prog_addr),
        .o_prog_wdata (w_prog_wdata),
        .o_busy       (w_busy),
        .o_done       (w_done),
        .o_err        (w_err),
        .o_cpu_hold   (w_cpu_hold),
        .o_start_pc   (w_start_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Scoreboard monitor: every write strobe pops one expected (addr, data) pair.
    always @(negedge clk) begin
        if (rst_n && w_prog_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write: unexpected write addr=%0d data=%h, expected none", w_prog_addr, w_prog_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (w_prog_addr !== e.addr || w_prog_wdata !== e.data || u_if.s_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h ready=%b, expected addr=%0d data=%h ready=0",
                             w_prog_addr, w_prog_wdata, u_if.s_ready, e.addr, e.data);
                end else begin
                    $display("ok   write addr=%0d data=%h", w_prog_addr, w_prog_wdata);
                end
            end
        end
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic [0:CFG_W-1] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy after start", 32'(w_busy), 32'd1);
        chk("cpu_hold after start", 32'(w_cpu_hold), 32'd1);
    endtask

    // Presents one byte after 'gap' idle cycles and returns 1ns after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        if (gap > 0) begin
            u_if.s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        u_if.s_data  = b;
        u_if.s_valid = 1'b1;
        t = 0;
        while (!u_if.s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL byte %h: not accepted within 50 cycles", b);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        u_if.s_valid = 1'b0;
    endtask

    task automatic good_frame(input int gap);
        send(8'h02, gap); send(8'h00, gap); send(8'h05, gap);
        send(8'hAB, gap); send(8'hC0, gap);
        send(8'h12, 0);   send(8'h30, gap);
        send(8'h4E, gap);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        u_if.s_data  = 8'h00;
        u_if.s_valid = 1'b0;
        #12;
        chk("rst s_ready", 32'(u_if.s_ready), 32'd0);
        chk("rst prog_we", 32'(w_prog_we), 32'd0);
        chk("rst prog_addr", 32'(w_prog_addr), 32'd0);
        chk("rst prog_wdata", 32'(w_prog_wdata), 32'd0);
        chk("rst busy", 32'(w_busy), 32'd0);
        chk("rst done", 32'(w_done), 32'd0);
        chk("rst err", 32'(w_err), 32'd0);
        chk("rst cpu_hold", 32'(w_cpu_hold), 32'd1);
        chk("rst start_pc", 32'(w_start_pc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-word good frame; CHK accepted at edge t, done at t+1, hold released at t+2.
        do_start();
        push_wr(2'd0, 12'hABC);
        push_wr(2'd1, 12'h123);
        good_frame(0);
        u_if.s_valid = 1'b0;
        @(negedge clk);
        chk("v1 done", 32'(w_done), 32'd1);
        chk("v1 busy", 32'(w_busy), 32'd0);
        chk("v1 cpu_hold t+1", 32'(w_cpu_hold), 32'd1);
        chk("v1 start_pc", 32'(w_start_pc), 32'd5);
        @(negedge clk);
        chk("v1 cpu_hold t+2", 32'(w_cpu_hold), 32'd0);
        chk("v1 pending writes", 32'(exp_q.size()), 32'd0);

        // Empty program.
        do_start();
        chk("v2 done cleared", 32'(w_done), 32'd0);
        send(8'h00, 0); send(8'h00, 0); send(8'h07, 0); send(8'h07, 0);
        end_frame();
        chk("v2 done", 32'(w_done), 32'd1);
        chk("v2 start_pc", 32'(w_start_pc), 32'd7);
        @(negedge clk);
        chk("v2 cpu_hold", 32'(w_cpu_hold), 32'd0);

        // Bad checksum: words still land, load fails.
        do_start();
        push_wr(2'd0, 12'hABC);
        push_wr(2'd1, 12'h123);
        send(8'h02, 0); send(8'h00, 0); send(8'h05, 0);
        send(8'hAB, 0); send(8'hC0, 0); send(8'h12, 0); send(8'h30, 0);
        send(8'hB1, 0);
        end_frame();
        chk("v3 err", 32'(w_err), 32'd1);
        chk("v3 done", 32'(w_done), 32'd0);
        repeat (2) @(negedge clk);
        chk("v3 cpu_hold", 32'(w_cpu_hold), 32'd1);
        chk("v3 pending writes", 32'(exp_q.size()), 32'd0);

        // Oversized count.
        do_start();
        send(8'h05, 0); send(8'h00, 0); send(8'h01, 0);
        end_frame();
        chk("v4 err", 32'(w_err), 32'd1);
        chk("v4 s_ready", 32'(u_if.s_ready), 32'd0);
        chk("v4 busy", 32'(w_busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("v4 cpu_hold", 32'(w_cpu_hold), 32'd1);

        // Backpressure: idle cycle between bytes, valid held through the WRITE cycle.
        do_start();
        push_wr(2'd0, 12'hABC);
        push_wr(2'd1, 12'h123);
        good_frame(1);
        end_frame();
        chk("v5 done", 32'(w_done), 32'd1);
        chk("v5 start_pc", 32'(w_start_pc), 32'd5);
        chk("v5 pending writes", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during the second payload byte, then a clean reload.
        do_start();
        send(8'h02, 0); send(8'h00, 0); send(8'h05, 0); send(8'hAB, 0);
        #2;
        u_if.s_data  = 8'hC0;
        u_if.s_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("v6 rst busy", 32'(w_busy), 32'd0);
        chk("v6 rst cpu_hold", 32'(w_cpu_hold), 32'd1);
        chk("v6 rst s_ready", 32'(u_if.s_ready), 32'd0);
        chk("v6 rst prog_wdata", 32'(w_prog_wdata), 32'd0);
        chk("v6 rst start_pc", 32'(w_start_pc), 32'd0);
        @(negedge clk);
        u_if.s_valid = 1'b0;
        rst_n = 1'b1;
        do_start();
        push_wr(2'd0, 12'hABC);
        push_wr(2'd1, 12'h123);
        good_frame(0);
        end_frame();
        chk("v6 done", 32'(w_done), 32'd1);
        chk("v6 start_pc", 32'(w_start_pc), 32'd5);
        @(negedge clk);
        chk("v6 cpu_hold", 32'(w_cpu_hold), 32'd0);
        chk("v6 pending writes", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
